// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the zero-register id and the default memory timeout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam int unsigned WAIT_MAX_DEF = 15;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: purely combinational, zero latency, no flow control.
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  // $zero is never a real producer, so a load targeting it cannot create a dependency.
  assign rs_match = id_uses_rs && (id_rs == ex_rt);
  assign rt_match = id_uses_rt && (id_rt == ex_rt);
  assign hazard   = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: memory wait/timeout, branch flush, load-use stall, stats.
// Control outputs are Mealy (zero-cycle) from registered state plus inputs; state updates on posedge.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [8:0]       wait_inc;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hazard;
  logic             mem_wait;
  logic             stall_inc, flush_inc;
  logic [3:0]       en_c;  // {pc, ifid, idex, exmem}
  logic [3:0]       fl_c;  // {ifid, idex, exmem, memwb}

  load_use_detect u_lud (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .hazard     (hazard)
  );

  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    wait_inc  = '0;
    en_c      = 4'b1111;
    fl_c      = 4'b0000;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      HALT: begin
        en_c = 4'b0000;
      end
      default: begin
        if (mem_wait) begin
          // Freeze everything up to MEM; a taken branch stays in MEM and flushes on release.
          en_c      = 4'b0000;
          fl_c      = 4'b0001;
          stall_inc = 1'b1;
          wait_inc  = (state_q == RUN) ? 9'd1 : ({1'b0, wait_q} + 9'd1);
          wait_d    = wait_inc[7:0];
          state_d   = (wait_inc >= 9'(WAIT_MAX)) ? HALT : MEM_WAIT;
        end else begin
          state_d = RUN;
          wait_d  = '0;
          if (mem_branch_taken) begin
            fl_c      = 4'b1110;
            flush_inc = 1'b1;
          end else if (hazard) begin
            en_c      = 4'b0011;
            fl_c      = 4'b0100;
            stall_inc = 1'b1;
          end
        end
      end
    endcase
  end

  assign stall_d = (stall_inc && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  assign flush_d = (flush_inc && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_q || (state_d == HALT);
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  // Reset forces a fully bubbled, frozen pipeline without waiting for a clock edge.
  assign {pc_en, ifid_en, idex_en, exmem_en}                 = rst ? en_c : 4'b0000;
  assign {ifid_flush, idex_flush, exmem_flush, memwb_bubble} = rst ? fl_c : 4'b1111;
  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two parameterisations driven in parallel, checked every cycle
// against a rule-level model, plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic       mem_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;

  logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en;
  logic        a_ifid_fl, a_idex_fl, a_exmem_fl, a_memwb_b, a_halted;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en;
  logic        b_ifid_fl, b_idex_fl, b_exmem_fl, b_memwb_b, b_halted;
  logic [3:0]  b_stall, b_flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en), .exmem_en(a_exmem_en),
    .ifid_flush(a_ifid_fl), .idex_flush(a_idex_fl), .exmem_flush(a_exmem_fl),
    .memwb_bubble(a_memwb_b), .halted(a_halted), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en), .exmem_en(b_exmem_en),
    .ifid_flush(b_ifid_fl), .idex_flush(b_idex_fl), .exmem_flush(b_exmem_fl),
    .memwb_bubble(b_memwb_b), .halted(b_halted), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int wmax [2] = '{15, 1};
  int cmax [2] = '{65535, 15};
  int m_wait [2], m_stall [2], m_flush [2];
  bit m_halt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_halt[k] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        bit haz, mw;
        int e_en, e_fl, d_en, d_fl, d_halt, d_stall, d_flush;
        if (!rst) begin
          m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_halt[k] = 0;
        end
        haz = ex_memread && (ex_rt != 0) &&
              ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        mw  = mem_req && !mem_ready;
        if (!rst)                  begin e_en = 'b0000; e_fl = 'b1111; end
        else if (m_halt[k])        begin e_en = 'b0000; e_fl = 'b0000; end
        else if (mw)               begin e_en = 'b0000; e_fl = 'b0001; end
        else if (mem_branch_taken) begin e_en = 'b1111; e_fl = 'b1110; end
        else if (haz)              begin e_en = 'b0011; e_fl = 'b0100; end
        else                       begin e_en = 'b1111; e_fl = 'b0000; end
        if (k == 0) begin
          d_en = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en};
          d_fl = {a_ifid_fl, a_idex_fl, a_exmem_fl, a_memwb_b};
          d_halt = a_halted; d_stall = a_stall; d_flush = a_flush;
        end else begin
          d_en = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en};
          d_fl = {b_ifid_fl, b_idex_fl, b_exmem_fl, b_memwb_b};
          d_halt = b_halted; d_stall = b_stall; d_flush = b_flush;
        end
        chk($sformatf("dut%0d enables", k), d_en, e_en);
        chk($sformatf("dut%0d flushes", k), d_fl, e_fl);
        chk($sformatf("dut%0d halted", k), d_halt, int'(m_halt[k]));
        chk($sformatf("dut%0d stall_cnt", k), d_stall, m_stall[k]);
        chk($sformatf("dut%0d flush_cnt", k), d_flush, m_flush[k]);
        // state advances at the coming posedge
        if (rst && !m_halt[k]) begin
          if (mw) begin
            m_wait[k]++;
            if (m_stall[k] < cmax[k]) m_stall[k]++;
            if (m_wait[k] >= wmax[k]) m_halt[k] = 1;
          end else begin
            m_wait[k] = 0;
            if (mem_branch_taken) begin
              if (m_flush[k] < cmax[k]) m_flush[k]++;
            end else if (haz) begin
              if (m_stall[k] < cmax[k]) m_stall[k]++;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic mr, input logic [4:0] ert,
                     input logic br, input logic rq, input logic rd);
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_memread = mr; ex_rt = ert; mem_branch_taken = br; mem_req = rq; mem_ready = rd;
  endtask

  task automatic idle(input logic r);
    cyc(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    idle(1'b0);
    idle(1'b1);
  endtask

  initial begin
    #1 rst = 1'b0;

    // reset forcing, then release to normal
    idle(1'b0);
    #4;
    chk("rst enables", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en}, 0);
    chk("rst flushes", {a_ifid_fl, a_idex_fl, a_exmem_fl, a_memwb_b}, 15);
    chk("rst stall_cnt", a_stall, 0);
    idle(1'b1);
    #4;
    chk("release pc_en", a_pc_en, 1);
    chk("release ifid_flush", a_ifid_fl, 0);

    // single load-use stall
    cyc(1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 1);
    #4;
    chk("lu pc_en", a_pc_en, 0);
    chk("lu ifid_en", a_ifid_en, 0);
    chk("lu idex_flush", a_idex_fl, 1);
    chk("lu idex_en", a_idex_en, 1);
    idle(1'b1);
    #4;
    chk("lu one cycle", a_pc_en, 1);
    chk("lu stall_cnt", a_stall, 1);
    cyc(1, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 1);
    #4;
    chk("lu rt0 no stall", a_pc_en, 1);

    // branch beats load-use
    do_reset();
    cyc(1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 0, 1);
    #4;
    chk("br flushes", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 7);
    chk("br pc_en", a_pc_en, 1);
    idle(1'b1);
    #4;
    chk("br flush_cnt", a_flush, 1);
    chk("br stall_cnt", a_stall, 0);

    // three-cycle memory wait then release
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #4;
      chk("mw pc_en", a_pc_en, 0);
      chk("mw memwb_bubble", a_memwb_b, 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #4;
    chk("mw release pc_en", a_pc_en, 1);
    chk("mw release bubble", a_memwb_b, 0);
    idle(1'b1);
    #4;
    chk("mw stall_cnt", a_stall, 3);
    chk("mw halted", a_halted, 0);

    // branch deferred across a memory wait
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      #4;
      chk("brmw ifid_flush", a_ifid_fl, 0);
      chk("brmw exmem_en", a_exmem_en, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #4;
    chk("brmw release flush", {a_ifid_fl, a_exmem_fl, a_pc_en}, 7);
    idle(1'b1);
    #4;
    chk("brmw flush_cnt", a_flush, 1);
    chk("brmw stall_cnt", a_stall, 2);

    // timeout: WAIT_MAX=15 on A, WAIT_MAX=1 on B
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #4;
      chk("to A not yet halted", a_halted, 0);
      if (i == 1) chk("to B not yet halted", b_halted, 0);
      if (i == 2) chk("to B halted", b_halted, 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #4;
    chk("to halted", a_halted, 1);
    chk("to enables", {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en}, 0);
    chk("to flushes", {a_ifid_fl, a_idex_fl, a_exmem_fl, a_memwb_b}, 0);
    chk("to stall_cnt", a_stall, 15);
    for (int i = 0; i < 4; i++) idle(1'b1);
    #4;
    chk("to sticky", a_halted, 1);
    chk("to stall frozen", a_stall, 15);
    idle(1'b0);
    #4;
    chk("to reset clears", a_halted, 0);
    idle(1'b1);

    // saturation with CNT_W=4 on B
    for (int i = 0; i < 20; i++) begin
      cyc(1, 5'd0, 5'd9, 0, 1, 1, 5'd9, 0, 0, 1);
      idle(1'b1);
    end
    #4;
    chk("sat A stall_cnt", a_stall, 20);
    chk("sat B stall_cnt", b_stall, 15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) < 7));
    end
    idle(1'b1);
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
